// File: rtl/fetch_stage_if.sv
// Fetch-stage bus bundle: instruction-memory request/response channel and the
// IF/ID register outputs seen by decode.
//   imem_req_o    fetch request this cycle
//   imem_addr_o   fetch byte address, bits[1:0]=0
//   imem_rdata_i  instruction for the request made the previous cycle
//   ifid_valid_o  IF/ID holds a live instruction
//   ifid_instr_o  IF/ID instruction (NOP when not valid)
//   ifid_pc_o     IF/ID instruction address
//   ifid_pc4_o    ifid_pc_o + 4, mod 2^32
// master: the fetch stage; slave: memory + decode side.
interface fetch_stage_if;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_rdata_i;
  logic        ifid_valid_o;
  logic [31:0] ifid_instr_o;
  logic [31:0] ifid_pc_o;
  logic [31:0] ifid_pc4_o;

  modport master (
    output imem_req_o,
    output imem_addr_o,
    input  imem_rdata_i,
    output ifid_valid_o,
    output ifid_instr_o,
    output ifid_pc_o,
    output ifid_pc4_o
  );

  modport slave (
    input  imem_req_o,
    input  imem_addr_o,
    output imem_rdata_i,
    input  ifid_valid_o,
    input  ifid_instr_o,
    input  ifid_pc_o,
    input  ifid_pc4_o
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch front end of the 5-stage MIPS pipeline.
// Owns the PC, drives a 1-cycle-latency synchronous instruction memory, feeds
// the IF/ID register, absorbs decode stalls in a 2-entry skid buffer and
// applies EX redirects by killing all younger fetches.
//   clk            pipeline clock, rising edge
//   rst            asynchronous, active-low reset
//   stall_i        decode hazard stall; IF/ID holds
//   redirect_i     EX taken branch/jump, one-cycle pulse
//   redirect_pc_i  redirect target
//   bus            imem request/response + IF/ID outputs (master side)
//   misalign_o     sticky: a redirect target had bits[1:0]!=0
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall_i,
  input  logic          redirect_i,
  input  logic [31:0]   redirect_pc_i,
  fetch_stage_if.master bus,
  output logic          misalign_o
);

  typedef enum logic [1:0] {IDLE, RUN, FULL} state_t;

  state_t           state, state_nxt;
  logic [31:0]      pc, pc_nxt;
  logic [1:0][31:0] skid_pc, skid_pc_nxt;
  logic [1:0][31:0] skid_instr, skid_instr_nxt;
  logic [1:0]       skid_count, skid_count_nxt;
  logic             inflight;
  logic [31:0]      inflight_pc;
  logic             ifid_valid, ifid_valid_nxt;
  logic [31:0]      ifid_instr, ifid_instr_nxt;
  logic [31:0]      ifid_pc, ifid_pc_nxt;
  logic [31:0]      ifid_pc4, ifid_pc4_nxt;
  logic             misalign, misalign_nxt;

  logic [1:0]       occ, occ_after, occ_nxt;
  logic             pop, fetch;
  logic [31:0]      fetch_addr;

  // Fetch control: occupancy counts buffered plus in-flight words; a new
  // request is allowed only if it cannot push occupancy past 2.
  always_comb begin
    occ        = skid_count + {1'b0, inflight};
    pop        = !stall_i && (occ != 2'd0);
    occ_after  = occ - {1'b0, pop};
    fetch      = redirect_i || (occ_after != 2'd2);
    fetch_addr = redirect_i ? {redirect_pc_i[31:2], 2'b00} : pc;
    pc_nxt     = fetch ? fetch_addr + 32'd4 : pc;
    misalign_nxt = misalign || (redirect_i && (redirect_pc_i[1:0] != 2'b00));
  end

  // IF/ID and skid update. The in-flight response is ignored on a redirect
  // since it belongs to a killed fetch.
  always_comb begin
    skid_pc_nxt    = skid_pc;
    skid_instr_nxt = skid_instr;
    skid_count_nxt = skid_count;
    ifid_valid_nxt = ifid_valid;
    ifid_instr_nxt = ifid_instr;
    ifid_pc_nxt    = ifid_pc;
    ifid_pc4_nxt   = ifid_pc4;
    if (redirect_i) begin
      skid_count_nxt = '0;
      ifid_valid_nxt = 1'b0;
      ifid_instr_nxt = NOP_INSTR;
    end else begin
      if (!stall_i) begin
        if (skid_count != 2'd0) begin
          ifid_valid_nxt    = 1'b1;
          ifid_instr_nxt    = skid_instr[0];
          ifid_pc_nxt       = skid_pc[0];
          ifid_pc4_nxt      = skid_pc[0] + 32'd4;
          skid_pc_nxt[0]    = skid_pc[1];
          skid_instr_nxt[0] = skid_instr[1];
          skid_count_nxt    = skid_count - 2'd1;
        end else if (inflight) begin
          ifid_valid_nxt = 1'b1;
          ifid_instr_nxt = bus.imem_rdata_i;
          ifid_pc_nxt    = inflight_pc;
          ifid_pc4_nxt   = inflight_pc + 32'd4;
        end else begin
          ifid_valid_nxt = 1'b0;
          ifid_instr_nxt = NOP_INSTR;
        end
      end
      // Response not consumed directly goes behind any remaining skid entry.
      if (inflight && (stall_i || (skid_count != 2'd0))) begin
        skid_pc_nxt[skid_count_nxt[0]]    = inflight_pc;
        skid_instr_nxt[skid_count_nxt[0]] = bus.imem_rdata_i;
        skid_count_nxt                    = skid_count_nxt + 2'd1;
      end
    end
  end

  always_comb begin
    occ_nxt   = skid_count_nxt + {1'b0, fetch};
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = RUN;
      RUN:     if (stall_i && (occ_nxt == 2'd2)) state_nxt = FULL;
      FULL:    if (!stall_i) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
    if (redirect_i) state_nxt = RUN;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc          <= RESET_PC;
      skid_pc     <= '0;
      skid_instr  <= '0;
      skid_count  <= '0;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      ifid_valid  <= 1'b0;
      ifid_instr  <= NOP_INSTR;
      ifid_pc     <= '0;
      ifid_pc4    <= '0;
      misalign    <= 1'b0;
    end else begin
      pc          <= pc_nxt;
      skid_pc     <= skid_pc_nxt;
      skid_instr  <= skid_instr_nxt;
      skid_count  <= skid_count_nxt;
      inflight    <= fetch;
      inflight_pc <= fetch_addr;
      ifid_valid  <= ifid_valid_nxt;
      ifid_instr  <= ifid_instr_nxt;
      ifid_pc     <= ifid_pc_nxt;
      ifid_pc4    <= ifid_pc4_nxt;
      misalign    <= misalign_nxt;
    end
  end

  // Request is held low while reset is asserted.
  assign bus.imem_req_o   = rst && fetch;
  assign bus.imem_addr_o  = fetch_addr;
  assign bus.ifid_valid_o = ifid_valid;
  assign bus.ifid_instr_o = ifid_instr;
  assign bus.ifid_pc_o    = ifid_pc;
  assign bus.ifid_pc4_o   = ifid_pc4;
  assign misalign_o       = misalign;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: cycle table for start-up and a mid-stream stall,
// hand sequences for redirect, redirect+stall, misaligned/wrapping targets and
// reset while full. An in-order scoreboard checks every word loaded into IF/ID.
module tb_fetch_stage;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        misalign;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  fetch_stage_if bus();

  fetch_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
    .clk(clk),
    .rst(rst),
    .stall_i(stall),
    .redirect_i(redirect),
    .redirect_pc_i(redirect_pc),
    .bus(bus),
    .misalign_o(misalign)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'h8C00_0000;
  endfunction

  // Synchronous-read instruction memory, one-cycle latency.
  always_ff @(posedge clk)
    bus.imem_rdata_i <= bus.imem_req_o ? word_of(bus.imem_addr_o) : 32'hBAD0_BAD0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic load_stream(input logic [31:0] start);
    exp_q.delete();
    for (int unsigned i = 0; i < 64; i++) exp_q.push_back(start + 32'(4 * i));
  endtask

  task automatic drive(input logic st, input logic rd, input logic [31:0] rpc);
    logic [31:0] tgt;
    stall = st;
    redirect = rd;
    redirect_pc = rpc;
    tgt = {rpc[31:2], 2'b00};
    if (rd) load_stream(tgt);
    #1;
  endtask

  task automatic clock(input logic st, input logic rd);
    logic [31:0] e;
    @(posedge clk);
    #1;
    if (rd) begin
      chk("flush_valid", {31'b0, bus.ifid_valid_o}, 32'd0);
      chk("flush_instr", bus.ifid_instr_o, NOP);
    end else if (!st && bus.ifid_valid_o) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow actual_pc=%h required=none", bus.ifid_pc_o);
      end else begin
        e = exp_q.pop_front();
        chk("sb_pc", bus.ifid_pc_o, e);
        chk("sb_instr", bus.ifid_instr_o, word_of(e));
        chk("sb_pc4", bus.ifid_pc4_o, e + 32'd4);
      end
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, {31'b0, bus.ifid_valid_o}, 32'd0);
    chk({tag, "_instr"}, bus.ifid_instr_o, NOP);
    chk({tag, "_pc"}, bus.ifid_pc_o, 32'd0);
    chk({tag, "_pc4"}, bus.ifid_pc4_o, 32'd0);
    chk({tag, "_misalign"}, {31'b0, misalign}, 32'd0);
    chk({tag, "_req"}, {31'b0, bus.imem_req_o}, 32'd0);
  endtask

  typedef struct {
    logic        stall;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t tbl[12];

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{1'b0, 1'b1, 32'h00, 1'b0, 32'h00};
    tbl[1]  = '{1'b0, 1'b1, 32'h04, 1'b1, 32'h00};
    tbl[2]  = '{1'b0, 1'b1, 32'h08, 1'b1, 32'h04};
    tbl[3]  = '{1'b0, 1'b1, 32'h0C, 1'b1, 32'h08};
    tbl[4]  = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h08};
    tbl[5]  = '{1'b1, 1'b0, 32'h14, 1'b1, 32'h08};
    tbl[6]  = '{1'b1, 1'b0, 32'h14, 1'b1, 32'h08};
    tbl[7]  = '{1'b1, 1'b0, 32'h14, 1'b1, 32'h08};
    tbl[8]  = '{1'b0, 1'b1, 32'h14, 1'b1, 32'h0C};
    tbl[9]  = '{1'b0, 1'b1, 32'h18, 1'b1, 32'h10};
    tbl[10] = '{1'b0, 1'b1, 32'h1C, 1'b1, 32'h14};
    tbl[11] = '{1'b0, 1'b1, 32'h20, 1'b1, 32'h18};

    rst = 1'b0;
    stall = 1'b0;
    redirect = 1'b0;
    redirect_pc = '0;
    #1;
    chk_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    load_stream(RESET_PC);

    // Start-up and a 4-cycle stall while IF/ID holds 0x8.
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].stall, 1'b0, '0);
      chk($sformatf("tbl%0d_req", i), {31'b0, bus.imem_req_o}, {31'b0, tbl[i].exp_req});
      if (tbl[i].exp_req) chk($sformatf("tbl%0d_addr", i), bus.imem_addr_o, tbl[i].exp_addr);
      clock(tbl[i].stall, 1'b0);
      chk($sformatf("tbl%0d_valid", i), {31'b0, bus.ifid_valid_o}, {31'b0, tbl[i].exp_valid});
      if (tbl[i].exp_valid) chk($sformatf("tbl%0d_pc", i), bus.ifid_pc_o, tbl[i].exp_pc);
    end

    // Fill the skid to two entries, then redirect to 0x100.
    drive(1'b1, 1'b0, '0);
    chk("full_req", {31'b0, bus.imem_req_o}, 32'd0);
    clock(1'b1, 1'b0);
    drive(1'b0, 1'b1, 32'h100);
    chk("redir_req", {31'b0, bus.imem_req_o}, 32'd1);
    chk("redir_addr", bus.imem_addr_o, 32'h100);
    clock(1'b0, 1'b1);
    drive(1'b0, 1'b0, '0);
    clock(1'b0, 1'b0);
    chk("redir_t0_valid", {31'b0, bus.ifid_valid_o}, 32'd1);
    chk("redir_t0_pc", bus.ifid_pc_o, 32'h100);
    drive(1'b0, 1'b0, '0);
    clock(1'b0, 1'b0);
    chk("redir_t1_pc", bus.ifid_pc_o, 32'h104);

    // Redirect and stall together: flush wins, target is next live entry.
    drive(1'b1, 1'b1, 32'h200);
    clock(1'b1, 1'b1);
    drive(1'b1, 1'b0, '0);
    clock(1'b1, 1'b0);
    chk("rs_hold_valid", {31'b0, bus.ifid_valid_o}, 32'd0);
    drive(1'b0, 1'b0, '0);
    clock(1'b0, 1'b0);
    chk("rs_t0_valid", {31'b0, bus.ifid_valid_o}, 32'd1);
    chk("rs_t0_pc", bus.ifid_pc_o, 32'h200);

    // Misaligned target: aligned fetch, sticky flag.
    drive(1'b0, 1'b1, 32'h102);
    chk("mis_addr", bus.imem_addr_o, 32'h100);
    chk("mis_pre", {31'b0, misalign}, 32'd0);
    clock(1'b0, 1'b1);
    chk("mis_set", {31'b0, misalign}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, '0);
      clock(1'b0, 1'b0);
    end
    chk("mis_sticky", {31'b0, misalign}, 32'd1);

    // Target at the top of the address space wraps to 0.
    drive(1'b0, 1'b1, 32'hFFFF_FFFC);
    chk("wrap_addr", bus.imem_addr_o, 32'hFFFF_FFFC);
    clock(1'b0, 1'b1);
    drive(1'b0, 1'b0, '0);
    chk("wrap_next_req", {31'b0, bus.imem_req_o}, 32'd1);
    chk("wrap_next_addr", bus.imem_addr_o, 32'h0);
    clock(1'b0, 1'b0);
    chk("wrap_pc", bus.ifid_pc_o, 32'hFFFF_FFFC);
    chk("wrap_pc4", bus.ifid_pc4_o, 32'h0);
    drive(1'b0, 1'b0, '0);
    clock(1'b0, 1'b0);
    chk("wrap_pc_next", bus.ifid_pc_o, 32'h0);
    chk("mis_sticky2", {31'b0, misalign}, 32'd1);

    // Reset asserted mid-cycle while full.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, '0);
      clock(1'b1, 1'b0);
    end
    chk("pre_rst_req", {31'b0, bus.imem_req_o}, 32'd0);
    #2;
    rst = 1'b0;
    stall = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    @(posedge clk);
    #1;
    chk_reset_outputs("rst_held");
    rst = 1'b1;
    load_stream(RESET_PC);
    drive(1'b0, 1'b0, '0);
    chk("rel_req", {31'b0, bus.imem_req_o}, 32'd1);
    chk("rel_addr", bus.imem_addr_o, RESET_PC);
    clock(1'b0, 1'b0);
    chk("rel_no_stale", {31'b0, bus.ifid_valid_o}, 32'd0);
    drive(1'b0, 1'b0, '0);
    clock(1'b0, 1'b0);
    chk("rel_first_valid", {31'b0, bus.ifid_valid_o}, 32'd1);
    chk("rel_first_pc", bus.ifid_pc_o, RESET_PC);
    drive(1'b0, 1'b0, '0);
    clock(1'b0, 1'b0);
    chk("rel_second_pc", bus.ifid_pc_o, RESET_PC + 32'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
